// File: rtl/mos6502_pkg.sv
// Shared 6502 control definitions: sequencer state/source enums, vector
// addresses and the address/write-data mux encodings.
package mos6502_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DUMMY,
    ST_PUSH_PCH,
    ST_PUSH_PCL,
    ST_PUSH_P,
    ST_VEC_LO,
    ST_VEC_HI
  } state_e;

  typedef enum logic [1:0] {
    SRC_RESET,
    SRC_NMI,
    SRC_IRQ,
    SRC_BRK
  } src_e;

  localparam logic [15:0] VEC_NMI = 16'hFFFA;
  localparam logic [15:0] VEC_RST = 16'hFFFC;
  localparam logic [15:0] VEC_IRQ = 16'hFFFE;

  localparam logic [1:0] ADDR_PC    = 2'b00;
  localparam logic [1:0] ADDR_STACK = 2'b01;
  localparam logic [1:0] ADDR_VEC   = 2'b10;

  localparam logic [1:0] DATA_PCH = 2'b00;
  localparam logic [1:0] DATA_PCL = 2'b01;
  localparam logic [1:0] DATA_P   = 2'b10;

  function automatic logic [15:0] base_vector(input src_e src);
    case (src)
      SRC_RESET: return VEC_RST;
      SRC_NMI:   return VEC_NMI;
      default:   return VEC_IRQ;
    endcase
  endfunction

endpackage

// File: rtl/nmi_edge_detect.sv
// Falling-edge detector for the active-low NMI pin with a sticky pending
// flag that survives until the sequencer services it.
module nmi_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic nmi,
  input  logic clear,
  output logic pend
);

  logic nmi_q, nmi_d;
  logic pend_q, pend_d;

  // A new edge wins over a same-cycle clear so it is never lost.
  always_comb begin
    nmi_d  = nmi;
    pend_d = (nmi_q & ~nmi) | (pend_q & ~clear);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      nmi_q  <= 1'b1;
      pend_q <= 1'b0;
    end else begin
      nmi_q  <= nmi_d;
      pend_q <= pend_d;
    end
  end

  assign pend = pend_q;

endmodule

// File: rtl/interrupt_sequencer.sv
// 6502 reset/NMI/IRQ/BRK push-and-vector sequencer. Define NMI_HIJACK_EN to
// let an NMI arriving during an IRQ/BRK sequence redirect its vector to FFFA.
module interrupt_sequencer #(
  parameter logic [7:0] STACK_PAGE = 8'h01
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rdy,
  input  logic        nmi,
  input  logic        irq,
  input  logic        i_flag,
  input  logic        fetch,
  input  logic        brk_req,
  output logic        busy,
  output logic        rw,
  output logic [1:0]  addr_sel,
  output logic [15:0] vector,
  output logic [1:0]  data_sel,
  output logic        b_flag,
  output logic        pc_inc,
  output logic        sp_dec,
  output logic        pcli,
  output logic        pchi,
  output logic        set_i,
  output logic        done
);

  import mos6502_pkg::*;

  state_e state_q, state_d;
  src_e   src_q, src_d;
  src_e   vec_src;
  logic   nmi_pend;
  logic   nmi_clear;
  logic   hold;
  logic   hijack;

  nmi_edge_detect u_nmi_edge_detect (
    .clk   (clk),
    .rst_n (rst_n),
    .nmi   (nmi),
    .clear (nmi_clear),
    .pend  (nmi_pend)
  );

`ifdef NMI_HIJACK_EN
  assign hijack = (state_q == ST_VEC_LO) && nmi_pend &&
                  ((src_q == SRC_IRQ) || (src_q == SRC_BRK));
`else
  assign hijack = 1'b0;
`endif

  always_comb begin
    vec_src  = hijack ? SRC_NMI : src_q;
    busy     = (state_q != ST_IDLE);
    rw       = 1'b1;
    addr_sel = ADDR_PC;
    data_sel = DATA_PCH;
    vector   = base_vector(vec_src);
    b_flag   = (src_q == SRC_BRK);
    pc_inc   = 1'b0;
    sp_dec   = 1'b0;
    pcli     = 1'b0;
    pchi     = 1'b0;
    set_i    = 1'b0;
    done     = 1'b0;
    case (state_q)
      ST_DUMMY: pc_inc = (src_q == SRC_BRK);
      ST_PUSH_PCH, ST_PUSH_PCL, ST_PUSH_P: begin
        addr_sel = ADDR_STACK;
        sp_dec   = 1'b1;
        rw       = (src_q == SRC_RESET);
        data_sel = (state_q == ST_PUSH_PCH) ? DATA_PCH :
                   (state_q == ST_PUSH_PCL) ? DATA_PCL : DATA_P;
      end
      ST_VEC_LO: begin
        addr_sel = ADDR_VEC;
        pcli     = 1'b1;
        set_i    = 1'b1;
      end
      ST_VEC_HI: begin
        addr_sel = ADDR_VEC;
        vector   = base_vector(vec_src) + 16'd1;
        pchi     = 1'b1;
        done     = 1'b1;
      end
      default: ;
    endcase
    // Read cycles stall on RDY low; writes always complete.
    hold = busy && rw && !rdy;
    if (hold) begin
      pc_inc = 1'b0;
      sp_dec = 1'b0;
      pcli   = 1'b0;
      pchi   = 1'b0;
      set_i  = 1'b0;
      done   = 1'b0;
    end
  end

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    nmi_clear = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fetch) begin
          if (brk_req) begin
            src_d   = SRC_BRK;
            state_d = ST_DUMMY;
          end else if (nmi_pend) begin
            src_d   = SRC_NMI;
            state_d = ST_DUMMY;
          end else if (!irq && !i_flag) begin
            src_d   = SRC_IRQ;
            state_d = ST_DUMMY;
          end
        end
      end
      ST_DUMMY:    if (!hold) state_d = ST_PUSH_PCH;
      ST_PUSH_PCH: if (!hold) state_d = ST_PUSH_PCL;
      ST_PUSH_PCL: if (!hold) state_d = ST_PUSH_P;
      ST_PUSH_P:   if (!hold) state_d = ST_VEC_LO;
      ST_VEC_LO: begin
        if (!hold) begin
          state_d   = ST_VEC_HI;
          nmi_clear = (src_q == SRC_NMI) || hijack;
          if (hijack) src_d = SRC_NMI;
        end
      end
      ST_VEC_HI:   if (!hold) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_DUMMY;
      src_q   <= SRC_RESET;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
    end
  end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Scoreboard bench for interrupt_sequencer: per-cycle expected outputs are
// queued as stimulus is driven and compared on the falling clock edge.
module tb_interrupt_sequencer;

  logic clk = 1'b0;
  logic rst_n, rdy, nmi, irq, i_flag, fetch, brk_req;
  logic busy, rw, b_flag, pc_inc, sp_dec, pcli, pchi, set_i, done;
  logic [1:0] addr_sel, data_sel;
  logic [15:0] vector;
  logic [31:0] obs;

  localparam logic [31:0] M_BUSY = 32'h1000_0000;
  localparam logic [31:0] M_RW   = 32'h0800_0000;
  localparam logic [31:0] M_ADDR = 32'h0600_0000;
  localparam logic [31:0] M_VEC  = 32'h01FF_FE00;
  localparam logic [31:0] M_DATA = 32'h0000_0180;
  localparam logic [31:0] M_B    = 32'h0000_0040;
  localparam logic [31:0] M_STB  = 32'h0000_003F;
  localparam logic [31:0] M_ALL  = 32'h1FFF_FFFF;

  localparam logic [5:0] STB_PCINC = 6'b100000;
  localparam logic [5:0] STB_SPDEC = 6'b010000;
  localparam logic [5:0] STB_PCLI  = 6'b001000;
  localparam logic [5:0] STB_PCHI  = 6'b000100;
  localparam logic [5:0] STB_SETI  = 6'b000010;
  localparam logic [5:0] STB_DONE  = 6'b000001;

  typedef struct {
    string       tag;
    logic [31:0] val;
    logic [31:0] care;
  } exp_t;

  exp_t sb[$];
  int compared   = 0;
  int mismatched = 0;

  interrupt_sequencer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rdy      (rdy),
    .nmi      (nmi),
    .irq      (irq),
    .i_flag   (i_flag),
    .fetch    (fetch),
    .brk_req  (brk_req),
    .busy     (busy),
    .rw       (rw),
    .addr_sel (addr_sel),
    .vector   (vector),
    .data_sel (data_sel),
    .b_flag   (b_flag),
    .pc_inc   (pc_inc),
    .sp_dec   (sp_dec),
    .pcli     (pcli),
    .pchi     (pchi),
    .set_i    (set_i),
    .done     (done)
  );

  always #5 clk = ~clk;

  assign obs = {3'b000, busy, rw, addr_sel, vector, data_sel, b_flag,
                pc_inc, sp_dec, pcli, pchi, set_i, done};

  function automatic logic [31:0] mkVal(input logic e_busy, input logic e_rw,
                                        input logic [1:0] e_addr, input logic [15:0] e_vec,
                                        input logic [1:0] e_data, input logic e_b,
                                        input logic [5:0] e_stb);
    return {3'b000, e_busy, e_rw, e_addr, e_vec, e_data, e_b, e_stb};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput(e.tag, obs & e.care, e.val & e.care);
    end
  end

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pushExp(input string tag, input logic [31:0] v, input logic [31:0] c);
    exp_t e;
    e.tag  = tag;
    e.val  = v;
    e.care = c;
    sb.push_back(e);
  endtask

  task automatic idleCycle(input string tag);
    pushExp(tag, 32'h0, M_BUSY | M_STB);
    nextCycle();
  endtask

  // One poll cycle: fetch high with the given request inputs, sequencer idle.
  task automatic applyStimulus(input string tag, input logic s_brk, input logic s_irq,
                               input logic s_iflag);
    fetch   = 1'b1;
    brk_req = s_brk;
    irq     = s_irq;
    i_flag  = s_iflag;
    pushExp(tag, 32'h0, M_BUSY | M_STB);
    nextCycle();
    fetch   = 1'b0;
    brk_req = 1'b0;
  endtask

  // Expected six-state sequence; stall_mask states get two RDY-low stall cycles.
  task automatic runSeq(input string tag, input logic is_brk, input logic is_rst,
                        input logic [15:0] vbase, input logic [5:0] stall_mask,
                        input int rdy_low_state, input int nmi_state);
    for (int k = 0; k < 6; k++) begin
      int stalls;
      stalls = stall_mask[k] ? 2 : 0;
      for (int j = 0; j <= stalls; j++) begin
        logic        st;
        logic [31:0] v, c;
        logic [5:0]  stb;
        st  = (j < stalls);
        rdy = (st || (k == rdy_low_state && j == 0)) ? 1'b0 : 1'b1;
        if (k == nmi_state && j == 0) nmi = 1'b0;
        c = M_BUSY | M_RW | M_ADDR | M_STB;
        v = 32'h0;
        case (k)
          0: begin
            stb = (is_brk && !st) ? STB_PCINC : 6'b0;
            v   = mkVal(1'b1, 1'b1, 2'b00, 16'h0, 2'b00, 1'b0, stb);
          end
          1, 2, 3: begin
            stb = st ? 6'b0 : STB_SPDEC;
            v   = mkVal(1'b1, is_rst, 2'b01, 16'h0, 2'(k - 1), (k == 3) ? is_brk : 1'b0, stb);
            c   = c | M_DATA | ((k == 3) ? M_B : 32'h0);
          end
          4: begin
            stb = st ? 6'b0 : (STB_PCLI | STB_SETI);
            v   = mkVal(1'b1, 1'b1, 2'b10, vbase, 2'b00, 1'b0, stb);
            c   = c | M_VEC;
          end
          default: begin
            stb = st ? 6'b0 : (STB_PCHI | STB_DONE);
            v   = mkVal(1'b1, 1'b1, 2'b10, 16'(vbase + 16'd1), 2'b00, 1'b0, stb);
            c   = c | M_VEC;
          end
        endcase
        pushExp($sformatf("%s_s%0d_%0d", tag, k, j), v, c);
        nextCycle();
      end
    end
    rdy = 1'b1;
  endtask

  logic [31:0] rst_val;

  initial begin
    rst_val = mkVal(1'b1, 1'b1, 2'b00, 16'hFFFC, 2'b00, 1'b0, 6'b0);
    rst_n = 1'b0; rdy = 1'b1; nmi = 1'b1; irq = 1'b1; i_flag = 1'b1;
    fetch = 1'b0; brk_req = 1'b0;
    nextCycle();

    for (int i = 0; i < 3; i++) begin
      pushExp("rst_hold", rst_val, M_ALL);
      nextCycle();
    end
    rst_n = 1'b1;
    runSeq("rst", 1'b0, 1'b1, 16'hFFFC, 6'b0, -1, -1);
    idleCycle("rst_idle");

    applyStimulus("irq_poll", 1'b0, 1'b0, 1'b0);
    runSeq("irq", 1'b0, 1'b0, 16'hFFFE, 6'b0, -1, -1);
    irq = 1'b1;
    idleCycle("irq_idle");

    applyStimulus("imask_poll", 1'b0, 1'b0, 1'b1);
    idleCycle("imask_idle0");
    idleCycle("imask_idle1");
    irq = 1'b1;

    applyStimulus("brk_poll", 1'b1, 1'b0, 1'b0);
    runSeq("brk", 1'b1, 1'b0, 16'hFFFE, 6'b0, -1, -1);
    irq = 1'b1;
    idleCycle("brk_idle");

    nmi = 1'b0;
    idleCycle("nmi_edge");
    applyStimulus("nmi_poll", 1'b0, 1'b0, 1'b0);
    runSeq("nmi", 1'b0, 1'b0, 16'hFFFA, 6'b0, -1, -1);
    nmi = 1'b1;
    idleCycle("nmi_idle");
    applyStimulus("nmi_irq_poll", 1'b0, 1'b0, 1'b0);
    runSeq("nmi_irq", 1'b0, 1'b0, 16'hFFFE, 6'b0, -1, -1);
    irq = 1'b1;
    idleCycle("nmi_irq_idle");

    applyStimulus("rdy_poll", 1'b0, 1'b0, 1'b0);
    runSeq("rdy", 1'b0, 1'b0, 16'hFFFE, 6'b010001, 1, -1);
    irq = 1'b1;
    idleCycle("rdy_idle");

    applyStimulus("hij_poll", 1'b1, 1'b1, 1'b0);
`ifdef NMI_HIJACK_EN
    runSeq("hij", 1'b1, 1'b0, 16'hFFFA, 6'b0, -1, 2);
    nmi = 1'b1;
    idleCycle("hij_idle");
    applyStimulus("hij_poll2", 1'b0, 1'b1, 1'b0);
    idleCycle("hij_none0");
    idleCycle("hij_none1");
`else
    runSeq("hij", 1'b1, 1'b0, 16'hFFFE, 6'b0, -1, 2);
    nmi = 1'b1;
    idleCycle("hij_idle");
    applyStimulus("hij_poll2", 1'b0, 1'b1, 1'b0);
    runSeq("hij_nmi", 1'b0, 1'b0, 16'hFFFA, 6'b0, -1, -1);
    idleCycle("hij_nmi_idle");
`endif

    applyStimulus("mrst_poll", 1'b0, 1'b0, 1'b0);
    nmi = 1'b0;
    pushExp("mrst_dummy", mkVal(1'b1, 1'b1, 2'b00, 16'h0, 2'b00, 1'b0, 6'b0),
            M_BUSY | M_RW | M_ADDR | M_STB);
    nextCycle();
    rst_n = 1'b0;
    nmi   = 1'b1;
    nextCycle();
    for (int i = 0; i < 2; i++) begin
      pushExp("mrst_hold", rst_val, M_ALL);
      nextCycle();
    end
    rst_n = 1'b1;
    irq   = 1'b1;
    runSeq("mrst", 1'b0, 1'b1, 16'hFFFC, 6'b0, -1, -1);
    idleCycle("mrst_idle");
    applyStimulus("mrst_poll2", 1'b0, 1'b1, 1'b0);
    idleCycle("mrst_none0");
    idleCycle("mrst_none1");

    nextCycle();
    checkOutput("drain", 32'(sb.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/interrupt_sequencer.md
# interrupt_sequencer

Sequencer that takes over the CPU control lines for the 6502 reset, NMI, IRQ and BRK sequences. It polls interrupt requests at instruction boundaries and runs the fixed push-and-vector cycle sequence. That sequence pushes PCH, PCL and P to the stack, then loads PC from FFFA/FFFC/FFFE. It sits beside `decoder`; while `busy` is high, its strobes replace the decoder's for the program counter, stack pointer and status register.

## Interface
Parameters:
- `STACK_PAGE`, 8'h01: high address byte used on stack cycles.

Ports:
- `clk` in 1: CPU clock; the only clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `rdy` in 1: high = run; low = stall read cycles.
- `nmi` in 1: active-low NMI pin, falling-edge sensitive.
- `irq` in 1: active-low IRQ pin, level sensitive.
- `i_flag` in 1: current interrupt-disable flag.
- `fetch` in 1: decoder is in the last cycle of an instruction (poll point).
- `brk_req` in 1: decoder decoded opcode 00 this cycle.
- `busy` out 1: sequence in progress; the decoder must not fetch.
- `rw` out 1: 1 = read, 0 = write.
- `addr_sel` out 2: address source. 00 = PC, 01 = {STACK_PAGE, SP}, 10 = `vector`.
- `vector` out 16: vector address for the current cycle.
- `data_sel` out 2: write-data source. 00 = PCH, 01 = PCL, 10 = P.
- `b_flag` out 1: B bit value for the pushed P.
- `pc_inc` out 1: increment PC this cycle.
- `sp_dec` out 1: decrement SP this cycle.
- `pcli`, `pchi` out 1 each: load PCL/PCH from the data bus.
- `set_i` out 1: set the I flag.
- `done` out 1: one-cycle pulse in the final sequence cycle.

## Operation
- States: IDLE → DUMMY → PUSH_PCH → PUSH_PCL → PUSH_P → VEC_LO → VEC_HI → IDLE.
- The sequence is 6 cycles after the triggering cycle.
- Source register `src` takes RESET, NMI, IRQ or BRK.
- Base vectors: RESET = FFFC, NMI = FFFA, IRQ/BRK = FFFE.
- `vector` = base in VEC_LO and base+1 in VEC_HI.
- Start conditions, evaluated in IDLE on the cycle `fetch` = 1:
  - `brk_req` → src = BRK.
  - else `nmi_pend` → NMI.
  - else (`irq` = 0 and `i_flag` = 0) → IRQ.
- Priority: RESET > BRK (it is the current opcode) > NMI > IRQ.
- DUMMY: `rw` = 1, `addr_sel` = PC. `pc_inc` = 1 only for BRK (skips the padding byte).
- PUSH_x states:
  - `addr_sel` = stack, `sp_dec` = 1.
  - `data_sel` = PCH, PCL, P in order.
  - `rw` = 0, except for RESET, where `rw` stays 1 (dummy reads).
- `b_flag` = 1 for BRK, 0 otherwise. It is valid in PUSH_P.
- VEC_LO: `addr_sel` = vector, `pcli` = 1, `set_i` = 1. NMI source clears `nmi_pend`.
- VEC_HI: `pchi` = 1, `done` = 1. Next state is IDLE with `busy` = 0.
- NMI edge detect: a registered previous `nmi` sample. A previous value of 1 with a current value of 0 sets `nmi_pend`.
  - The pending flag persists until serviced.
  - Edges during a sequence stay pending for the next poll.
- RDY:
  - `rdy` = 0 in any non-IDLE cycle with `rw` = 1 holds the state.
  - While held, `pc_inc`, `sp_dec`, `pcli`, `pchi`, `set_i` and `done` are forced to 0.
  - Write cycles ignore `rdy`.
  - RESET dummy pushes are reads and therefore stall.

## Timing
- While `rst_n` = 0, registered outputs are:
  - state = DUMMY, src = RESET;
  - `busy` = 1, `rw` = 1, `addr_sel` = 00, `data_sel` = 00, `vector` = FFFC;
  - `b_flag` = 0, `nmi_pend` = 0, NMI sample = 1;
  - all strobes 0.
- The first cycle after release is DUMMY of the RESET sequence, with normal strobes.
- `rst_n` = 0 mid-sequence aborts it on the next edge and discards `src` and `nmi_pend`.
- All outputs are combinational from state/src and valid in the same cycle as the state.
- Start latency: `busy` rises on the edge after the poll cycle.
- Minimum `nmi` low pulse: one full cycle sampled low after a high sample.
- `fetch` = 1 with `busy` = 1 is ignored.

## Configuration
- `NMI_HIJACK_EN` defined:
  - An NMI edge detected in an IRQ or BRK sequence before VEC_LO redirects the vector to FFFA.
  - It also consumes `nmi_pend` at VEC_LO.
  - `b_flag` keeps the original source's value.
- `NMI_HIJACK_EN` undefined: the vector is fixed at sequence start, and the NMI stays pending for the next poll.

## Structure
- Shared package `mos6502_pkg` holds:
  - the state enum and source enum;
  - vector constants `VEC_NMI`, `VEC_RST`, `VEC_IRQ`;
  - the `addr_sel`/`data_sel` encodings.
- Sub-module `nmi_edge_detect` (clk, rst_n, nmi, clear → pend) holds the sample and pending registers.

## Test plan
- Reset: `rst_n` low 3 cycles then high, `rdy` = 1 → 6 cycles with `rw` = 1 throughout and `sp_dec` = 1 three times. `vector` = FFFC then FFFD. `done` pulses in cycle 6, then `busy` = 0.
- IRQ: `irq` = 0, `i_flag` = 0, `fetch` pulse → `rw` = 0 for three cycles with `data_sel` 00/01/10 and `b_flag` = 0. Then `pcli`/`set_i` at FFFE, `pchi` at FFFF. With `i_flag` = 1, nothing starts.
- BRK with `irq` = 0 at the same `fetch` → BRK source, `pc_inc` = 1 in DUMMY, `b_flag` = 1, vector FFFE.
- NMI edge while `irq` = 0 at the poll → NMI sequence (FFFA, `b_flag` = 0), `nmi_pend` cleared. The following IRQ sequence starts at the next poll.
- `rdy` = 0 for 2 cycles in DUMMY and in VEC_LO → state holds 2 cycles each with strobes 0. `rdy` = 0 during PUSH_PCH → no stall. Total length is 10 cycles.
- `NMI_HIJACK_EN`: NMI edge during PUSH_PCL of a BRK → vector FFFA/FFFB with `b_flag` = 1 and no second NMI sequence. Without the macro: vector FFFE, then an NMI sequence at the next poll.
